// File: rtl/dcache_dm_wb_if.sv
`default_nettype none
// ============================================================================
// Module : dcache_dm_wb_if
// Brief  : CPU-side and line-wide backing-memory bus of the direct-mapped cache
// Rev    : 1.0
// ============================================================================
interface dcache_dm_wb_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int OFFSET_LOG = 3
);
  localparam int LINE_W = 32 << OFFSET_LOG;

  logic                  rd_req;
  logic                  wr_req;
  logic [ADDR_WIDTH-1:0] addr;
  logic [3:0]            byte_en;
  logic [31:0]           wr_data;
  logic [31:0]           rd_data;
  logic                  miss;
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [LINE_W-1:0]     mem_wdata;
  logic [LINE_W-1:0]     mem_rdata;
  logic                  mem_ready;

  modport slave (
    input  rd_req, wr_req, addr, byte_en, wr_data, mem_rdata, mem_ready,
    output rd_data, miss, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output rd_req, wr_req, addr, byte_en, wr_data, mem_rdata, mem_ready,
    input  rd_data, miss, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/dcache_dm_wb.sv
`default_nettype none
// ============================================================================
// Module : dcache_dm_wb
// Brief  : Direct-mapped write-back write-allocate data cache; DCACHE_STATS_EN
//          adds hit/miss counters.
// Rev    : 1.0
// ============================================================================
module dcache_dm_wb #(
  parameter int ADDR_WIDTH = 32,
  parameter int OFFSET_LOG = 3,
  parameter int SET_LOG    = 4
) (
  input  wire                clk,
  input  wire                rst_n,
`ifdef DCACHE_STATS_EN
  output logic [31:0]        hit_cnt,
  output logic [31:0]        miss_cnt,
`endif
  dcache_dm_wb_if.slave      bus
);
  localparam int TAG_W   = ADDR_WIDTH - SET_LOG - OFFSET_LOG - 2;
  localparam int LINE_W  = 32 << OFFSET_LOG;
  localparam int SETS    = 1 << SET_LOG;
  localparam int LSB_IDX = OFFSET_LOG + 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WB   = 2'd1,
    S_FILL = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [LINE_W-1:0]            data_q [SETS];
  logic [TAG_W-1:0]             tag_q  [SETS];
  logic [SETS-1:0]              valid_q, dirty_q;
  logic [ADDR_WIDTH-LSB_IDX-1:0] req_line_q;
  logic [31:0]                  rd_data_q;
  logic                         mem_req_q, mem_we_q;
  logic [ADDR_WIDTH-1:0]        mem_addr_q;
  logic [LINE_W-1:0]            mem_wdata_q;

  logic [OFFSET_LOG-1:0] w_off;
  logic [SET_LOG-1:0]    w_idx, w_req_idx;
  logic [TAG_W-1:0]      w_tag, w_req_tag;
  logic                  w_req, w_hit, w_idle, w_wr_hit, w_rd_hit, w_ready;
  logic                  w_unused;

  assign w_off     = bus.addr[OFFSET_LOG+1:2];
  assign w_idx     = bus.addr[LSB_IDX +: SET_LOG];
  assign w_tag     = bus.addr[ADDR_WIDTH-1 -: TAG_W];
  assign w_req_idx = req_line_q[SET_LOG-1:0];
  assign w_req_tag = req_line_q[ADDR_WIDTH-LSB_IDX-1 -: TAG_W];
  assign w_unused  = ^bus.addr[1:0];

  assign w_req    = bus.rd_req | bus.wr_req;
  assign w_hit    = valid_q[w_idx] && (tag_q[w_idx] == w_tag);
  assign w_idle   = (state_q == S_IDLE);
  assign w_wr_hit = w_idle & bus.wr_req & w_hit;
  assign w_rd_hit = w_idle & bus.rd_req & ~bus.wr_req & w_hit;
  assign w_ready  = ~w_idle & bus.mem_ready;

  // Gated by rst_n so a request held through reset does not report a stall.
  assign bus.miss      = rst_n & (~w_idle | (w_req & ~w_hit));
  assign bus.rd_data   = rd_data_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (w_req && !w_hit)
                state_d = (valid_q[w_idx] && dirty_q[w_idx]) ? S_WB : S_FILL;
      S_WB:   if (bus.mem_ready) state_d = S_FILL;
      S_FILL: if (bus.mem_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= '0;
      dirty_q     <= '0;
      req_line_q  <= '0;
      rd_data_q   <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (w_rd_hit) rd_data_q <= data_q[w_idx][{w_off, 5'b0} +: 32];
          if (w_wr_hit && (|bus.byte_en)) dirty_q[w_idx] <= 1'b1;
          if (w_req && !w_hit) begin
            req_line_q <= bus.addr[ADDR_WIDTH-1:LSB_IDX];
            mem_req_q  <= 1'b1;
            if (valid_q[w_idx] && dirty_q[w_idx]) begin
              mem_we_q    <= 1'b1;
              mem_addr_q  <= {tag_q[w_idx], w_idx, {LSB_IDX{1'b0}}};
              mem_wdata_q <= data_q[w_idx];
            end else begin
              mem_we_q    <= 1'b0;
              mem_addr_q  <= {w_tag, w_idx, {LSB_IDX{1'b0}}};
            end
          end
        end
        S_WB: if (bus.mem_ready) begin
          dirty_q[w_req_idx] <= 1'b0;
          mem_we_q           <= 1'b0;
          mem_addr_q         <= {req_line_q, {LSB_IDX{1'b0}}};
        end
        S_FILL: if (bus.mem_ready) begin
          valid_q[w_req_idx] <= 1'b1;
          dirty_q[w_req_idx] <= 1'b0;
          mem_req_q          <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Arrays carry no reset; valid_q alone decides whether their contents count.
  always_ff @(posedge clk) begin
    if (w_ready && (state_q == S_FILL)) begin
      data_q[w_req_idx] <= bus.mem_rdata;
      tag_q[w_req_idx]  <= w_req_tag;
    end else if (w_wr_hit) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.byte_en[b])
          data_q[w_idx][{w_off, 5'b0} + 8*b +: 8] <= bus.wr_data[8*b +: 8];
      end
    end
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (w_idle && w_req && w_hit)  hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (w_idle && w_req && !w_hit) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dcache_dm_wb.sv
`default_nettype none
// ============================================================================
// Module : tb_dcache_dm_wb
// Brief  : Directed self-checking bench for dcache_dm_wb
// Rev    : 1.0
// ============================================================================
module tb_dcache_dm_wb;
  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  dcache_dm_wb_if #(.ADDR_WIDTH(32), .OFFSET_LOG(3)) bus ();

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  dcache_dm_wb #(.ADDR_WIDTH(32), .OFFSET_LOG(3), .SET_LOG(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef DCACHE_STATS_EN
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt),
`endif
    .bus      (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_line(input logic [31:0] base);
    for (int k = 0; k < 8; k++) bus.mem_rdata[32*k +: 32] = base + 32'(k);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    rst_n         = 1'b0;
    bus.rd_req    = 1'b1;
    bus.wr_req    = 1'b0;
    bus.addr      = 32'h40;
    bus.byte_en   = 4'h0;
    bus.wr_data   = 32'h0;
    bus.mem_rdata = '0;
    bus.mem_ready = 1'b0;

    // Reset with a read already pending: stall must stay low.
    repeat (3) step();
    chk("rst_miss",    32'(bus.miss), 32'd0);
    chk("rst_rd_data", bus.rd_data, 32'd0);
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_mem_we",  32'(bus.mem_we), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata[31:0], 32'd0);

    // Cold read miss on 0x40, refill 0x1000.., then hit
    rst_n = 1'b1;
    #1 chk("s1_miss", 32'(bus.miss), 32'd1);
    step();
    chk("s1_mem_req",  32'(bus.mem_req), 32'd1);
    chk("s1_mem_we",   32'(bus.mem_we), 32'd0);
    chk("s1_mem_addr", bus.mem_addr, 32'h40);
    set_line(32'h1000);
    bus.mem_ready = 1'b1;
    step();
    bus.mem_ready = 1'b0;
    #1 chk("s1_miss_after_fill", 32'(bus.miss), 32'd0);
    chk("s1_mem_req_drop", 32'(bus.mem_req), 32'd0);
    step();
    chk("s1_rd_data", bus.rd_data, 32'h1000);
    bus.rd_req = 1'b0;

    // Write-hit byte merge on 0x44, then read back
    bus.wr_req  = 1'b1;
    bus.addr    = 32'h44;
    bus.byte_en = 4'b0010;
    bus.wr_data = 32'hAABBCCDD;
    #1 chk("s2_wr_miss", 32'(bus.miss), 32'd0);
    step();
    chk("s2_rd_data_hold", bus.rd_data, 32'h1000);
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b1;
    step();
    chk("s2_merge", bus.rd_data, 32'h0000CC01);
    bus.rd_req = 1'b0;

    // Dirty conflict on 0x240: write-back of 0x40 with stable outputs over a 7-cycle delay
    bus.rd_req = 1'b1;
    bus.addr   = 32'h240;
    #1 chk("s3_miss", 32'(bus.miss), 32'd1);
    step();
    chk("s3_wb_req",   32'(bus.mem_req), 32'd1);
    chk("s3_wb_we",    32'(bus.mem_we), 32'd1);
    chk("s3_wb_addr",  bus.mem_addr, 32'h40);
    chk("s3_wb_word0", bus.mem_wdata[31:0], 32'h1000);
    chk("s3_wb_word1", bus.mem_wdata[63:32], 32'h0000CC01);
    chk("s3_wb_word7", bus.mem_wdata[255:224], 32'h1007);
    bus.addr = 32'h840;
    for (int i = 0; i < 7; i++) begin
      step();
      chk("s3_hold_req",   32'(bus.mem_req), 32'd1);
      chk("s3_hold_we",    32'(bus.mem_we), 32'd1);
      chk("s3_hold_addr",  bus.mem_addr, 32'h40);
      chk("s3_hold_word1", bus.mem_wdata[63:32], 32'h0000CC01);
      chk("s3_hold_miss",  32'(bus.miss), 32'd1);
    end
    bus.mem_ready = 1'b1;
    step();
    bus.mem_ready = 1'b0;
    chk("s3_fill_req",  32'(bus.mem_req), 32'd1);
    chk("s3_fill_we",   32'(bus.mem_we), 32'd0);
    chk("s3_fill_addr", bus.mem_addr, 32'h240);
    bus.addr = 32'h240;
    set_line(32'h2000);
    bus.mem_ready = 1'b1;
    step();
    bus.mem_ready = 1'b0;
    #1 chk("s3_miss_after_fill", 32'(bus.miss), 32'd0);
    step();
    chk("s3_rd_data", bus.rd_data, 32'h2000);
    bus.rd_req = 1'b0;

    // Clean conflict on 0x440: straight to refill
    bus.rd_req = 1'b1;
    bus.addr   = 32'h440;
    #1 chk("s4_miss", 32'(bus.miss), 32'd1);
    step();
    chk("s4_req",  32'(bus.mem_req), 32'd1);
    chk("s4_we",   32'(bus.mem_we), 32'd0);
    chk("s4_addr", bus.mem_addr, 32'h440);
    set_line(32'h3000);
    bus.mem_ready = 1'b1;
    step();
    bus.mem_ready = 1'b0;
    step();
    chk("s4_rd_data", bus.rd_data, 32'h3000);
    bus.rd_req = 1'b0;

`ifdef DCACHE_STATS_EN
    chk("stats_miss_cnt", miss_cnt, 32'd3);
    chk("stats_hit_cnt",  hit_cnt,  32'd5);
`endif

    // Stray mem_ready in IDLE is ignored
    set_line(32'hDEAD0000);
    bus.mem_ready = 1'b1;
    repeat (2) step();
    bus.mem_ready = 1'b0;
    chk("idle_ready_req", 32'(bus.mem_req), 32'd0);
    bus.rd_req = 1'b1;
    bus.addr   = 32'h44C;
    #1 chk("idle_ready_miss", 32'(bus.miss), 32'd0);
    step();
    chk("idle_ready_rd", bus.rd_data, 32'h3003);
    bus.rd_req = 1'b0;

    // byte_en=0 write: a hit with no data change and no dirty bit
    bus.wr_req  = 1'b1;
    bus.addr    = 32'h440;
    bus.byte_en = 4'b0000;
    bus.wr_data = 32'hFFFFFFFF;
    #1 chk("be0_miss", 32'(bus.miss), 32'd0);
    step();
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b1;
    step();
    chk("be0_rd_data", bus.rd_data, 32'h3000);
    bus.addr = 32'h40;
    #1 chk("be0_conflict_miss", 32'(bus.miss), 32'd1);
    step();
    chk("be0_no_wb_we",   32'(bus.mem_we), 32'd0);
    chk("be0_no_wb_addr", bus.mem_addr, 32'h40);

    // Reset mid-FILL while memory is slow
    repeat (5) step();
    chk("s5_fill_pending", 32'(bus.mem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("s5_async_req",  32'(bus.mem_req), 32'd0);
    chk("s5_async_miss", 32'(bus.miss), 32'd0);
    chk("s5_async_addr", bus.mem_addr, 32'd0);
    repeat (2) step();
    rst_n = 1'b1;
    #1 chk("s5_remiss", 32'(bus.miss), 32'd1);
    step();
    chk("s5_req",  32'(bus.mem_req), 32'd1);
    chk("s5_we",   32'(bus.mem_we), 32'd0);
    chk("s5_addr", bus.mem_addr, 32'h40);
    set_line(32'h4000);
    bus.mem_ready = 1'b1;
    step();
    bus.mem_ready = 1'b0;
    step();
    chk("s5_rd_data", bus.rd_data, 32'h4000);

    // Simultaneous rd/wr acts as a write and leaves rd_data alone
    bus.wr_req  = 1'b1;
    bus.byte_en = 4'b1111;
    bus.wr_data = 32'h12345678;
    step();
    chk("rw_rd_hold", bus.rd_data, 32'h4000);
    bus.wr_req = 1'b0;
    step();
    chk("rw_rd_data", bus.rd_data, 32'h12345678);

    // That write dirtied the line: a conflict must write it back first
    bus.addr = 32'h240;
    #1 chk("rw_conflict_miss", 32'(bus.miss), 32'd1);
    step();
    chk("rw_wb_we",    32'(bus.mem_we), 32'd1);
    chk("rw_wb_addr",  bus.mem_addr, 32'h40);
    chk("rw_wb_word0", bus.mem_wdata[31:0], 32'h12345678);
    bus.rd_req = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
